// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard AXI4-Lite receiver: register map,
// STATUS/CTRL bit positions and the frame receiver state encoding.
package ps2_kbd_pkg;

    localparam int unsigned OFF_DATA   = 0;
    localparam int unsigned OFF_STATUS = 4;
    localparam int unsigned OFF_CTRL   = 8;
    localparam int unsigned OFF_ERRCNT = 12;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_OVF   = 2;
    localparam int unsigned ST_PERR  = 3;
    localparam int unsigned ST_FERR  = 4;
    localparam int unsigned ST_COUNT = 16;

    localparam int unsigned CTRL_RX_EN  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_FLUSH  = 2;

    localparam logic [2:0] CTRL_RESET = 3'b001;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock glitch filter,
// frame FSM with inactivity timeout. Emits one-cycle byte/error pulses.
module ps2_frame_rx
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_perr,
    output logic       rx_ferr
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_filt;
    logic             clk_filt_d;
    logic [FLT_W-1:0] flt_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       bit_cnt;
    logic             par_ok;
    rx_state_t        state;
    rx_state_t        state_next;
    logic             dat_c;
    logic             fall_c;
    logic             timeout_c;
    logic             good_c;
    logic             perr_c;
    logic             ferr_c;

    assign dat_c     = dat_sync[1];
    assign fall_c    = clk_filt_d && !clk_filt;
    assign timeout_c = (state != IDLE) && !fall_c && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_data};
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!rx_en) begin
            state_next = IDLE;
        end else if (fall_c) begin
            case (state)
                IDLE:    if (!dat_c) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end else if (timeout_c) begin
            state_next = IDLE;
        end
    end

    // A bad stop bit is reported as framing even if parity was also wrong
    always_comb begin
        good_c = 1'b0;
        perr_c = 1'b0;
        ferr_c = 1'b0;
        if (rx_en && fall_c && state == STOP) begin
            if (!dat_c)       ferr_c = 1'b1;
            else if (!par_ok) perr_c = 1'b1;
            else              good_c = 1'b1;
        end
        if (rx_en && timeout_c) ferr_c = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            tmo_cnt  <= '0;
            bit_cnt  <= '0;
            par_ok   <= 1'b0;
        end else begin
            rx_valid <= good_c;
            rx_perr  <= perr_c;
            rx_ferr  <= ferr_c;
            if (state == IDLE || fall_c) tmo_cnt <= '0;
            else                         tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (state == IDLE) bit_cnt <= '0;
            if (fall_c && state == DATA) begin
                rx_byte <= {dat_c, rx_byte[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fall_c && state == PARITY) par_ok <= ^{dat_c, rx_byte};
        end
    end

endmodule

// File: rtl/ps2_kbd_axil_rx_fifo.sv
// PS/2 keyboard receiver with scan-code FIFO, AXI4-Lite register interface
// (DATA/STATUS/CTRL/ERRCNT) and level interrupt.
module ps2_kbd_axil_rx_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned FILTER_LEN         = 4,
    parameter int unsigned TIMEOUT_CYCLES     = 20000
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    output logic                            irq,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [AW-1:0] A_DATA   = AW'(OFF_DATA);
    localparam logic [AW-1:0] A_STATUS = AW'(OFF_STATUS);
    localparam logic [AW-1:0] A_CTRL   = AW'(OFF_CTRL);
    localparam logic [AW-1:0] A_ERRCNT = AW'(OFF_ERRCNT);

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_perr;
    logic             rx_ferr;
    logic             rx_en;
    logic             irq_en;
    logic             flush;
    logic             ovf;
    logic             perr;
    logic             ferr;
    logic [15:0]      errcnt;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic          empty_c, full_c, wr_hs_c, rd_hs_c;
    logic          wr_ctrl_c, wr_stat_c, wr_err_c, pop_c, push_c, ovf_set_c;
    logic [15:0]   errcnt_c;
    logic [DW-1:0] rdata_c;
    logic          unused_bits;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk     (ACLK),
        .rst     (ARESET),
        .rx_en   (rx_en),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_perr (rx_perr),
        .rx_ferr (rx_ferr)
    );

    assign unused_bits = ^{S_AXI_WDATA[DW-1:5], S_AXI_WSTRB[DW/8-1:1]};
    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;

    assign empty_c   = (count == '0);
    assign full_c    = (count == CNT_W'(FIFO_DEPTH));
    assign wr_hs_c   = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_hs_c   = S_AXI_ARREADY && S_AXI_ARVALID;
    assign wr_ctrl_c = wr_hs_c && (S_AXI_AWADDR == A_CTRL);
    assign wr_stat_c = wr_hs_c && (S_AXI_AWADDR == A_STATUS);
    assign wr_err_c  = wr_hs_c && (S_AXI_AWADDR == A_ERRCNT);
    assign pop_c     = rd_hs_c && (S_AXI_ARADDR == A_DATA) && !empty_c;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign push_c    = rx_valid && (!full_c || pop_c);
    assign ovf_set_c = rx_valid && full_c && !pop_c;

    always_comb begin
        errcnt_c = wr_err_c ? 16'h0000 : errcnt;
        if ((rx_perr || rx_ferr) && errcnt_c != 16'hFFFF) errcnt_c = errcnt_c + 16'd1;
    end

    always_comb begin
        rdata_c = '0;
        if (S_AXI_ARADDR == A_DATA) begin
            rdata_c[7:0] = empty_c ? 8'h00 : mem[rd_ptr];
            rdata_c[8]   = !empty_c;
        end else if (S_AXI_ARADDR == A_STATUS) begin
            rdata_c[ST_EMPTY]          = empty_c;
            rdata_c[ST_FULL]           = full_c;
            rdata_c[ST_OVF]            = ovf;
            rdata_c[ST_PERR]           = perr;
            rdata_c[ST_FERR]           = ferr;
            rdata_c[ST_COUNT +: CNT_W] = count;
        end else if (S_AXI_ARADDR == A_CTRL) begin
            rdata_c[CTRL_RX_EN]  = rx_en;
            rdata_c[CTRL_IRQ_EN] = irq_en;
            rdata_c[CTRL_FLUSH]  = flush;
        end else if (S_AXI_ARADDR == A_ERRCNT) begin
            rdata_c[15:0] = errcnt;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push_c) mem[wr_ptr] <= rx_byte;
    end

    // Flush takes priority over any push or pop in the same cycle
    always_ff @(posedge ACLK) begin
        if (ARESET || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rx_en  <= CTRL_RESET[CTRL_RX_EN];
            irq_en <= CTRL_RESET[CTRL_IRQ_EN];
            flush  <= CTRL_RESET[CTRL_FLUSH];
            ovf    <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            errcnt <= '0;
            irq    <= 1'b0;
        end else begin
            flush <= wr_ctrl_c && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_FLUSH];
            if (wr_ctrl_c && S_AXI_WSTRB[0]) begin
                rx_en  <= S_AXI_WDATA[CTRL_RX_EN];
                irq_en <= S_AXI_WDATA[CTRL_IRQ_EN];
            end
            ovf    <= ovf_set_c || (ovf  && !(wr_stat_c && S_AXI_WDATA[ST_OVF]));
            perr   <= rx_perr   || (perr && !(wr_stat_c && S_AXI_WDATA[ST_PERR]));
            ferr   <= rx_ferr   || (ferr && !(wr_stat_c && S_AXI_WDATA[ST_FERR]));
            errcnt <= errcnt_c;
            irq    <= irq_en && (!empty_c || ovf || perr || ferr);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
            S_AXI_WREADY  <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
            if (wr_hs_c)           S_AXI_BVALID <= 1'b1;
            else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
            if (rd_hs_c) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rdata_c;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ps2_kbd_axil_rx_fifo.md
Name: ps2_kbd_axil_rx_fifo

Overview:
Parametrised successor to the single-register PS/2 keyboard AXI4-Lite peripheral. It receives PS/2 device-to-host frames, checks start, parity and stop bits, and buffers scan codes in a configurable-depth FIFO. It exposes data, status, control and error-count registers over AXI4-Lite, plus a level interrupt. It sits behind the PS AXI interconnect, beside the other capstone IP.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 registers at 0x0/0x4/0x8/0xC.
FIFO_DEPTH, 16, scan-code FIFO entries; power of 2, 2..256.
FILTER_LEN, 4, consecutive equal synced samples required before the filtered ps2_clk changes.
TIMEOUT_CYCLES, 20000, ACLK cycles without a falling edge mid-frame before the frame is aborted.

Ports:
ACLK  in  1  system clock, all logic on rising edge
ARESET  in  1  synchronous active-high reset
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
irq  out  1  level interrupt
S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  AXI4-Lite write channels, widths per parameters (AWPROT ignored)
S_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  AXI4-Lite read channels (ARPROT ignored)

Behaviour:
- Reset values: all READY/VALID = 0, RDATA = 0, RESP = 0, irq = 0. FIFO is empty, sticky flags and ERRCNT are 0, CTRL = 0x1 (rx_en=1, irq_en=0). Receiver FSM is in IDLE.
- Input path: 2-FF synchronisers on both pins. A clock filter updates only after FILTER_LEN identical samples. A falling edge of the filtered clock gives a one-cycle sample strobe; data is sampled from the synced ps2_data.
- Receiver FSM, states IDLE -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: a strobe with data=0 enters DATA; data=1 stays in IDLE.
  - DATA: takes 8 bits, LSB first.
  - PARITY: computes odd parity over the 8 data bits plus the parity bit.
  - STOP: stop bit must be 1.
  - Good frame: a push request is issued in the cycle after the stop sample.
  - Parity error: set PERR and increment ERRCNT; no push.
  - Stop bit = 0: set FERR and increment ERRCNT; no push.
  - Timeout: the counter resets on each strobe. Reaching TIMEOUT_CYCLES outside IDLE forces IDLE, sets FERR and increments ERRCNT.
  - rx_en=0: FSM is held in IDLE; a frame in progress is discarded silently.
- FIFO: a push when full drops the new byte and sets OVF. A pop when empty has no effect.
  - Simultaneous push and pop when full: both succeed; count is unchanged.
  - Simultaneous push and pop when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH; count runs 0..FIFO_DEPTH.
- Register map:
  - 0x0 DATA (RO): [7:0] head byte, [8] valid (= !empty). A read handshake while non-empty pops the FIFO; RDATA holds the pre-pop value.
  - 0x4 STATUS: [0] empty, [1] full, [2] OVF, [3] PERR, [4] FERR, [16+:] count. Bits 2-4 are write-1-to-clear; if a set event and a clear land in the same cycle, set wins.
  - 0x8 CTRL (RW): [0] rx_en, [1] irq_en, [2] flush (self-clearing; empties the FIFO the cycle after the write; a flush beats a same-cycle push).
  - 0xC ERRCNT (R, any write clears): 16-bit count that saturates at 0xFFFF.
  - Unmapped addresses read 0; writes to them are ignored. RRESP/BRESP are always OKAY.
- AXI handshake:
  - Write: AWREADY and WREADY pulse together for 1 cycle when AWVALID && WVALID && !BVALID. The register updates on that edge. BVALID rises the next cycle and holds until BREADY.
  - Read: ARREADY pulses 1 cycle when ARVALID && !RVALID. RDATA/RVALID are registered the next cycle and held until RREADY.
  - One outstanding transaction per channel.
  - WSTRB is honoured per byte for CTRL only.
- irq = irq_en && (!empty || OVF || PERR || FERR), registered with 1-cycle latency.
- ARESET mid-frame or mid-transaction: everything returns to reset values the next cycle. A pending BVALID/RVALID is dropped.

Decomposition:
- Package ps2_kbd_pkg:
  - register offsets (DATA/STATUS/CTRL/ERRCNT);
  - STATUS/CTRL bit indices;
  - rx_state_t enum {IDLE, DATA, PARITY, STOP};
  - reset value of CTRL.
- Sub-module ps2_frame_rx: synchronisers, filter, FSM, timeout. Outputs: byte, valid pulse, perr pulse, ferr pulse.
- FIFO and AXI-Lite register logic live in the top level.

Test Plan:
- Frame 0x1C with correct odd parity at ~12 kHz, then read 0x0 -> RDATA=0x11C. A second read -> 0x000, STATUS.empty=1.
- Frame 0xF0 with a bad parity bit -> FIFO stays empty, STATUS.PERR=1, ERRCNT=1. Write 0x8 to 0x4 -> PERR=0.
- 17 frames 0x00..0x10 with FIFO_DEPTH=16 -> count=16, full=1, OVF=1. Reads return 0x00..0x0F in order; 0x10 is lost.
- Stop after 5 data bits and wait > TIMEOUT_CYCLES -> FERR=1, FSM back in IDLE. The next frame 0x5A is received correctly.
- CTRL=0x3, send 0x29 -> irq rises; read DATA -> irq falls within 2 cycles. Write CTRL flush with 3 bytes queued -> count=0.
- Glitch (ps2_clk low for < FILTER_LEN cycles) during IDLE -> no state change. ARESET asserted mid-frame -> all registers return to reset values.
